regfile_wb_arbiter: RTL and testbench

Write-back arbiter for the shared register file write port. Collects register write requests from NUM_REQ execution pipes (LSU, ALUs, MUL), buffers each pipe's requests in a private DEPTH-entry FIFO and grants one write per cycle round-robin. Drives the register file's single write port (wr_en/wr_addr/wr_data) from registered outputs. Writes to register 0 are consumed and discarded.

---
 rtl/regfile_wb_arbiter.sv | 133 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the shared register file write port: per-pipe FIFOs,
// round-robin grant, registered wr_* outputs; writes to register 0 are dropped.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DEPTH   = 2,
  parameter int AW      = 5,
  parameter int DW      = 32,
  localparam int IW     = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  wr_en,
  output logic [AW-1:0]         wr_addr,
  output logic [DW-1:0]         wr_data,
  output logic [IW-1:0]         grant_id,
  output logic                  busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0]      q_addr [NUM_REQ][DEPTH];
  logic [DW-1:0]      q_data [NUM_REQ][DEPTH];
  logic [PW-1:0]      wp [NUM_REQ];
  logic [PW-1:0]      rp [NUM_REQ];
  logic [CW-1:0]      cnt [NUM_REQ];

  logic [NUM_REQ-1:0] nonempty;
  logic [NUM_REQ-1:0] full;
  logic [NUM_REQ-1:0] push;
  logic [NUM_REQ-1:0] pop_sel;
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      gnt;
  logic [IW-1:0]      nxt_ptr;
  logic               gnt_vld;
  logic               do_pop;
  logic [AW-1:0]      head_addr;
  logic [DW-1:0]      head_data;

  // Ready depends on occupancy only, so a full FIFO never accepts even when popped.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      nonempty[i]  = (cnt[i] != '0);
      full[i]      = (cnt[i] == CW'(DEPTH));
      req_ready[i] = !full[i] && !rst;
      push[i]      = req_valid[i] && req_ready[i] && !flush;
    end
  end

  always_comb begin
    int idx;
    gnt     = '0;
    gnt_vld = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_vld && nonempty[idx]) begin
        gnt_vld = 1'b1;
        gnt     = IW'(idx);
      end
    end
  end

  always_comb begin
    do_pop    = gnt_vld && !flush;
    head_addr = q_addr[gnt][rp[gnt]];
    head_data = q_data[gnt][rp[gnt]];
    nxt_ptr   = (int'(gnt) == NUM_REQ - 1) ? '0 : gnt + IW'(1);
    for (int i = 0; i < NUM_REQ; i++) begin
      pop_sel[i] = do_pop && (gnt == IW'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt[i] <= '0;
        wp[i]  <= '0;
        rp[i]  <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt[i] <= '0;
        wp[i]  <= '0;
        rp[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (push[i])    wp[i] <= wp[i] + PW'(1);
        if (pop_sel[i]) rp[i] <= rp[i] + PW'(1);
        cnt[i] <= cnt[i] + CW'(push[i]) - CW'(pop_sel[i]);
      end
    end
  end

  // Storage needs no reset: occupancy counters define which slots are valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (push[i]) begin
        q_addr[i][wp[i]] <= req_addr[i*AW +: AW];
        q_data[i][wp[i]] <= req_data[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      grant_id <= '0;
      rr_ptr   <= '0;
    end else if (flush) begin
      wr_en <= 1'b0;
    end else if (do_pop) begin
      wr_en    <= (head_addr != '0);
      wr_addr  <= head_addr;
      wr_data  <= head_data;
      grant_id <= gnt;
      rr_ptr   <= nxt_ptr;
    end else begin
      wr_en <= 1'b0;
    end
  end

  assign busy = (|nonempty) || wr_en;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: single write, round-robin, backpressure,
// register 0 discard, flush and asynchronous reset mid-burst.
module tb_regfile_wb_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DEPTH   = 2;
  localparam int AW      = 5;
  localparam int DW      = 32;
  localparam int IW      = $clog2(NUM_REQ);

  logic                  clk;
  logic                  rst;
  logic                  flush;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [DW-1:0]         wr_data;
  logic [IW-1:0]         grant_id;
  logic                  busy;

  int n_cmp = 0;
  int n_err = 0;

  regfile_wb_arbiter #(.NUM_REQ(NUM_REQ), .DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]         = v;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic clr_req();
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  logic [DW-1:0] a_tab [7];
  logic [DW-1:0] b_tab [4];
  logic [DW-1:0] exp_d [8];
  logic [IW-1:0] exp_g [8];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a_tab = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003,
              32'hA000_0003, 32'hA000_0004, 32'hA000_0004};
    b_tab = '{32'hB000_0000, 32'hB000_0001, 32'hB000_0002, 32'hB000_0002};
    exp_d = '{32'hA000_0000, 32'hB000_0000, 32'hA000_0001, 32'hB000_0001,
              32'hA000_0002, 32'hB000_0002, 32'hA000_0003, 32'hA000_0004};
    exp_g = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd0};

    rst   = 1'b1;
    flush = 1'b0;
    clr_req();

    // reset state
    #2;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_ready", req_ready, 4'hF);

    // single write
    set_req(1, 1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    clr_req();
    chk("single_nobypass", wr_en, 0);
    chk("single_busy_q", busy, 1);
    tick();
    chk("single_wr_en", wr_en, 1);
    chk("single_addr", wr_addr, 5);
    chk("single_data", wr_data, 32'hDEADBEEF);
    chk("single_grant", grant_id, 1);
    tick();
    chk("single_wr_en_off", wr_en, 0);
    chk("single_busy_off", busy, 0);

    // round-robin
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, AW'(i + 1), DW'(32'h100 + i));
    tick();
    clr_req();
    for (int g = 0; g < NUM_REQ; g++) begin
      tick();
      chk("rr_wr_en", wr_en, 1);
      chk("rr_grant", grant_id, g);
      chk("rr_addr", wr_addr, g + 1);
      chk("rr_data", wr_data, 32'h100 + g);
    end
    tick();
    chk("rr_wr_en_off", wr_en, 0);
    chk("rr_busy_off", busy, 0);

    // backpressure: requester 0 saturates, requester 2 pushes three entries
    do_reset();
    for (int c = 0; c < 10; c++) begin
      if (c <= 6) set_req(0, 1'b1, 5'd10, a_tab[c]);
      else        set_req(0, 1'b0, 5'd0, 32'h0);
      if (c <= 3) set_req(2, 1'b1, 5'd20, b_tab[c]);
      else        set_req(2, 1'b0, 5'd0, 32'h0);
      tick();
      if (c >= 1 && c <= 8) begin
        chk("bp_wr_en", wr_en, 1);
        chk("bp_data", wr_data, exp_d[c-1]);
        chk("bp_grant", grant_id, exp_g[c-1]);
      end
      if (c == 1) chk("bp_ready2_full", req_ready[2], 0);
      if (c == 2) begin
        chk("bp_ready2_free", req_ready[2], 1);
        chk("bp_ready0_full", req_ready[0], 0);
      end
      if (c == 9) begin
        chk("bp_wr_en_off", wr_en, 0);
        chk("bp_busy_off", busy, 0);
      end
    end
    clr_req();

    // register 0 discard, pointer still advances past requester 3
    do_reset();
    set_req(3, 1'b1, 5'd0, 32'h33);
    tick();
    set_req(3, 1'b1, 5'd7, 32'h77);
    set_req(0, 1'b1, 5'd9, 32'h99);
    tick();
    clr_req();
    chk("r0_wr_en", wr_en, 0);
    chk("r0_grant", grant_id, 3);
    chk("r0_busy", busy, 1);
    tick();
    chk("r0_next_grant", grant_id, 0);
    chk("r0_next_addr", wr_addr, 9);
    chk("r0_next_wr_en", wr_en, 1);
    tick();
    chk("r0_a7_grant", grant_id, 3);
    chk("r0_a7_addr", wr_addr, 7);
    chk("r0_a7_data", wr_data, 32'h77);
    chk("r0_a7_wr_en", wr_en, 1);
    tick();
    chk("r0_wr_en_off", wr_en, 0);

    // flush with five entries queued
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, AW'(16 + i), DW'(32'hF0 + i));
    tick();
    clr_req();
    set_req(1, 1'b1, 5'd20, 32'hE1);
    set_req(2, 1'b1, 5'd21, 32'hE2);
    tick();
    chk("fl_pre_grant", grant_id, 0);
    chk("fl_pre_addr", wr_addr, 16);
    clr_req();
    set_req(3, 1'b1, 5'd22, 32'hE3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    clr_req();
    chk("fl_wr_en", wr_en, 0);
    chk("fl_busy", busy, 0);
    chk("fl_ready", req_ready, 4'hF);
    chk("fl_addr_hold", wr_addr, 16);
    tick();
    chk("fl_wr_en2", wr_en, 0);
    chk("fl_busy2", busy, 0);
    set_req(0, 1'b1, 5'd3, 32'h300);
    set_req(1, 1'b1, 5'd4, 32'h400);
    tick();
    clr_req();
    tick();
    chk("fl_ptr_grant1", grant_id, 1);
    chk("fl_ptr_data1", wr_data, 32'h400);
    tick();
    chk("fl_ptr_grant0", grant_id, 0);
    chk("fl_ptr_data0", wr_data, 32'h300);
    tick();
    chk("fl_end_wr_en", wr_en, 0);

    // asynchronous reset mid-burst
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, AW'(i + 1), DW'(32'h600 + i));
    tick();
    clr_req();
    tick();
    chk("ar_burst0", wr_en, 1);
    tick();
    chk("ar_burst1_grant", grant_id, 1);
    chk("ar_burst1_wr_en", wr_en, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_wr_en", wr_en, 0);
    chk("ar_busy", busy, 0);
    chk("ar_ready", req_ready, 0);
    rst = 1'b0;
    set_req(0, 1'b1, 5'd11, 32'h711);
    set_req(2, 1'b1, 5'd12, 32'h712);
    tick();
    clr_req();
    tick();
    chk("ar_first_grant", grant_id, 0);
    chk("ar_first_addr", wr_addr, 11);
    tick();
    chk("ar_second_grant", grant_id, 2);
    chk("ar_second_data", wr_data, 32'h712);
    tick();
    chk("ar_end_wr_en", wr_en, 0);
    chk("ar_end_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
